// File: rtl/elliot_act_arbiter.sv
// Round-robin scheduler sharing one Elliot activation unit among N_REQ requesters.
// Latches the winner's operands, starts the unit, waits for completion or watchdog, returns y.
module elliot_act_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned S_W     = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_x,
  input  logic [N_REQ*S_W-1:0]    req_s,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  output logic [DATA_W-1:0]       y_out,
  output logic                    err,
  output logic                    busy,
  output logic [DATA_W-1:0]       act_x,
  output logic [S_W-1:0]          act_s,
  output logic                    act_start,
  input  logic [DATA_W-1:0]       act_y,
  input  logic                    act_end
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned SumW = IdxW + 1;
  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [TmrW-1:0]     timer_q, timer_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [N_REQ-1:0]    done_q, done_d;
  logic [DATA_W-1:0]   y_q, y_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   act_x_q, act_x_d;
  logic [S_W-1:0]      act_s_q, act_s_d;
  logic                act_start_q, act_start_d;

  logic [DATA_W-1:0]   x_arr [N_REQ];
  logic [S_W-1:0]      s_arr [N_REQ];

  logic                win_found;
  logic [IdxW-1:0]     win_idx;
  logic [SumW-1:0]     cand_sum;
  logic [IdxW-1:0]     cand;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign x_arr[g] = req_x[g*DATA_W +: DATA_W];
    assign s_arr[g] = req_s[g*S_W +: S_W];
  end

  // Scan ptr, ptr+1, ... wrapping at N_REQ; the first asserted request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand_sum = {1'b0, ptr_q} + SumW'(i);
      if (cand_sum >= SumW'(N_REQ)) begin
        cand_sum = cand_sum - SumW'(N_REQ);
      end
      cand = cand_sum[IdxW-1:0];
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    grant_d     = '0;
    done_d      = '0;
    y_d         = '0;
    err_d       = 1'b0;
    act_x_d     = act_x_q;
    act_s_d     = act_s_q;
    act_start_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          idx_d            = win_idx;
          grant_d[win_idx] = 1'b1;
          act_start_d      = 1'b1;
          act_x_d          = x_arr[win_idx];
          act_s_d          = s_arr[win_idx];
          state_d          = StIssue;
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        // A completion on the watchdog's last cycle still counts as a valid result.
        if (act_end) begin
          y_d           = act_y;
          err_d         = 1'b0;
          done_d[idx_q] = 1'b1;
          state_d       = StResp;
        end else if (timer_q == TmrW'(TIMEOUT - 1)) begin
          y_d           = '0;
          err_d         = 1'b1;
          done_d[idx_q] = 1'b1;
          state_d       = StResp;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StResp: begin
        ptr_d   = (idx_q == IdxW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      idx_q       <= '0;
      timer_q     <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      y_q         <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      act_x_q     <= '0;
      act_s_q     <= '0;
      act_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      y_q         <= y_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      act_x_q     <= act_x_d;
      act_s_q     <= act_s_d;
      act_start_q <= act_start_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign y_out     = y_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign act_x     = act_x_q;
  assign act_s     = act_s_q;
  assign act_start = act_start_q;

endmodule

// File: tb/tb_elliot_act_arbiter.sv
// Bench for elliot_act_arbiter: activation-unit model, round-robin reference model and a
// done-side scoreboard fed with expected responses at grant time.
module tb_elliot_act_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 8;
  localparam int unsigned TO = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_x = '0;
  logic [N*SW-1:0] req_s = '0;
  logic [N-1:0]    grant, done;
  logic [DW-1:0]   y_out;
  logic            err, busy;
  logic [DW-1:0]   act_x;
  logic [SW-1:0]   act_s;
  logic            act_start;
  logic [DW-1:0]   act_y = '0;
  logic            act_end = 1'b0;

  elliot_act_arbiter #(
    .N_REQ  (N),
    .DATA_W (DW),
    .S_W    (SW),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_x    (req_x),
    .req_s    (req_s),
    .grant    (grant),
    .done     (done),
    .y_out    (y_out),
    .err      (err),
    .busy     (busy),
    .act_x    (act_x),
    .act_s    (act_s),
    .act_start(act_start),
    .act_y    (act_y),
    .act_end  (act_end)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            idx;
    logic [DW-1:0] y;
    logic          err;
    int            due;
  } exp_t;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            done_cnt = 0;
  bit            mon_en   = 1'b0;
  exp_t          sb_q[$];
  int            gseq[$];

  // Snapshots of what the DUT saw at each rising edge.
  int              cyc = 0;
  logic [N-1:0]    req_seen = '0;
  logic [N*DW-1:0] x_seen = '0;
  logic [N*SW-1:0] s_seen = '0;
  logic            rst_seen = 1'b1;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    req_seen <= req;
    x_seen   <= req_x;
    s_seen   <= req_s;
    rst_seen <= rst;
  end

  // Reference model state (transaction level).
  int            mptr = 0;
  int            due = -10;
  int            end_at = -1;
  logic [DW-1:0] end_y = '0;
  int            lat_mode = 1;
  int            lat_fix = 5;
  bit            y_ovr_en = 1'b0;
  logic [DW-1:0] y_ovr = '0;
  logic [N-1:0]  hold = '0;

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, got, exp);
    end
  endfunction

  function automatic logic [N-1:0] onehot(int w);
    logic [N-1:0] v;
    v    = '0;
    v[0] = 1'b1;
    return v << w;
  endfunction

  function automatic int rr_pick(logic [N-1:0] r, int start);
    logic [N-1:0] t;
    for (int k = 0; k < N; k++) begin
      t = r >> ((start + k) % N);
      if (t[0]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] op_x(logic [N*DW-1:0] v, int w);
    logic [N*DW-1:0] t;
    t = v >> (w * DW);
    return t[DW-1:0];
  endfunction

  function automatic logic [SW-1:0] op_s(logic [N*SW-1:0] v, int w);
    logic [N*SW-1:0] t;
    t = v >> (w * SW);
    return t[SW-1:0];
  endfunction

  function automatic logic [DW-1:0] act_fn(logic [DW-1:0] x, logic [SW-1:0] s);
    return (x ^ 32'h5A5A_0F0F) + {24'h0, s};
  endfunction

  // Activation unit model plus grant/operand checking; pushes the expected response.
  initial begin : stim
    bit            exp_g;
    int            w;
    int            lat;
    bit            resp;
    logic [DW-1:0] ex, ey;
    logic [SW-1:0] es;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (cyc == end_at) begin
        act_end = 1'b1;
        act_y   = end_y;
      end else begin
        act_end = 1'b0;
        act_y   = '0;
      end
      if (mon_en && !rst_seen) begin
        exp_g = (cyc >= due + 2) && (req_seen != '0);
        w     = exp_g ? rr_pick(req_seen, mptr) : 0;
        check("grant", 64'(grant), exp_g ? 64'(onehot(w)) : 64'(0));
        check("act_start", 64'(act_start), 64'(exp_g));
        if (exp_g) begin
          ex = op_x(x_seen, w);
          es = op_s(s_seen, w);
          check("act_x", 64'(act_x), 64'(ex));
          check("act_s", 64'(act_s), 64'(es));
          mptr = (w + 1) % N;
          case (lat_mode)
            0: begin
              if ($urandom_range(0, 9) == 0) lat = TO;
              else if ($urandom_range(0, 9) == 0) lat = 0;
              else lat = int'($urandom_range(1, 12));
            end
            1: lat = lat_fix;
            default: lat = 0;
          endcase
          resp = (lat >= 1) && (lat <= TO);
          ey   = y_ovr_en ? y_ovr : act_fn(ex, es);
          if (resp) begin
            end_at = cyc + lat;
            end_y  = ey;
            due    = cyc + lat + 1;
          end else begin
            due = cyc + TO + 1;
          end
          e.idx = w;
          e.y   = resp ? ey : '0;
          e.err = !resp;
          e.due = due;
          sb_q.push_back(e);
        end
      end
    end
  end

  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        if (done != '0) begin
          done_cnt++;
          if (sb_q.size() == 0) begin
            check("spurious_done", 64'(done), 64'(0));
          end else begin
            e = sb_q.pop_front();
            check("done", 64'(done), 64'(onehot(e.idx)));
            check("y_out", 64'(y_out), 64'(e.y));
            check("err", 64'(err), 64'(e.err));
            check("done_cycle", 64'(cyc), 64'(e.due));
            check("busy_resp", 64'(busy), 64'(1));
          end
        end else begin
          if (sb_q.size() != 0 && cyc > sb_q[0].due) begin
            e = sb_q.pop_front();
            check("done_missing", 64'(done), 64'(onehot(e.idx)));
          end
          if (err) check("err_without_done", 64'(err), 64'(0));
          check("busy", 64'(busy), 64'(sb_q.size() != 0));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (grant == onehot(i)) gseq.push_back(i);
    end
    req = req & ~(grant & ~hold);
  endtask

  task automatic set_op(int i, logic [DW-1:0] x, logic [SW-1:0] s);
    logic [N*DW-1:0] mx;
    logic [N*SW-1:0] ms;
    mx    = {{(N*DW-DW){1'b0}}, {DW{1'b1}}} << (i * DW);
    ms    = {{(N*SW-SW){1'b0}}, {SW{1'b1}}} << (i * SW);
    req_x = (req_x & ~mx) | ({{(N*DW-DW){1'b0}}, x} << (i * DW));
    req_s = (req_s & ~ms) | ({{(N*SW-SW){1'b0}}, s} << (i * SW));
    req   = req | onehot(i);
  endtask

  task automatic do_reset(bit keep_end);
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_y_out", 64'(y_out), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_act_x", 64'(act_x), 64'(0));
    check("rst_act_s", 64'(act_s), 64'(0));
    check("rst_act_start", 64'(act_start), 64'(0));
    sb_q.delete();
    due  = -10;
    mptr = 0;
    if (!keep_end) end_at = -1;
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic wait_done(int target, int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt < target) check("wait_done", 64'(done_cnt), 64'(target));
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    if (sb_q.size() != 0 || busy) check("drain", 64'({busy, sb_q.size() != 0}), 64'(0));
  endtask

  initial begin : driver
    int base;
    int n;
    int t2_exp[5] = '{0, 1, 2, 3, 0};
    do_reset(1'b0);

    // Single request with a fixed 20-cycle unit.
    lat_mode = 1;
    lat_fix  = 20;
    y_ovr_en = 1'b1;
    y_ovr    = 32'h0000_AAAA;
    set_op(0, 32'h0001_0000, 8'd2);
    wait_done(done_cnt + 1, 200);
    y_ovr_en = 1'b0;

    // Pointer now past requester 0: requester 2 must go first.
    lat_fix = 4;
    base    = gseq.size();
    set_op(0, 32'h1111_0000, 8'd5);
    set_op(2, 32'h2222_0000, 8'd7);
    wait_done(done_cnt + 2, 200);
    if (gseq.size() >= base + 2) begin
      check("t3_first", 64'(gseq[base]), 64'(2));
      check("t3_second", 64'(gseq[base+1]), 64'(0));
    end else begin
      check("t3_grants", 64'(gseq.size() - base), 64'(2));
    end

    // Watchdog abort, then a normal service.
    lat_mode = 2;
    set_op(1, 32'hDEAD_BEEF, 8'd3);
    wait_done(done_cnt + 1, 200);
    lat_mode = 1;
    lat_fix  = 3;
    set_op(3, 32'h0000_0033, 8'd1);
    wait_done(done_cnt + 1, 200);

    // Completion on the watchdog's last cycle, then a stray act_end while idle.
    lat_fix = TO;
    set_op(2, 32'h0BAD_CAFE, 8'd9);
    wait_done(done_cnt + 1, 200);
    wait_idle(50);
    end_at = cyc + 3;
    repeat (8) tick();
    check("stray_busy", 64'(busy), 64'(0));
    lat_fix = 2;
    set_op(1, 32'h0000_0101, 8'd4);
    wait_done(done_cnt + 1, 200);

    // Contention with every requester holding its request.
    do_reset(1'b0);
    lat_fix = 5;
    base    = gseq.size();
    hold    = '1;
    for (int i = 0; i < N; i++) set_op(i, DW'(i + 1), SW'(i));
    wait_done(done_cnt + 5, 300);
    hold = '0;
    req  = '0;
    wait_idle(100);
    if (gseq.size() >= base + 5) begin
      for (int k = 0; k < 5; k++) check("t2_order", 64'(gseq[base+k]), 64'(t2_exp[k]));
    end else begin
      check("t2_grants", 64'(gseq.size() - base), 64'(5));
    end

    // Reset five cycles after act_start; the late act_end must be ignored.
    do_reset(1'b0);
    lat_fix = 20;
    set_op(1, 32'h1234_5678, 8'd6);
    n = 0;
    while (grant == '0 && n < 20) begin
      tick();
      n++;
    end
    check("t5_grant", 64'(grant), 64'(onehot(1)));
    repeat (4) tick();
    do_reset(1'b1);
    repeat (25) tick();
    check("t5_busy", 64'(busy), 64'(0));

    // Randomized traffic with forfeits, re-requests and random unit latency.
    do_reset(1'b0);
    lat_mode = 0;
    for (int c = 0; c < 1500; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if ((req & onehot(i)) == '0) begin
          if ($urandom_range(0, 3) == 0) set_op(i, DW'($urandom), SW'($urandom));
        end else if ($urandom_range(0, 39) == 0) begin
          req = req & ~onehot(i);
        end
      end
    end
    req = '0;
    wait_idle(200);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d failures=%0d",
             n_checks, n_fail);
    $fatal(1, "global timeout");
  end

endmodule
